// File: rtl/can_bit_destuff.sv
// CAN receive-path bit de-stuffer: removes stuff bits from the sampled bus
// stream, flags stuff errors and assembles the de-stuffed bits into bytes.
module can_bit_destuff #(
  parameter int unsigned STUFF_LEN = 5,
  parameter int unsigned BYTE_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              rx_bit,
  input  logic              destuff_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              stuff_drop,
  output logic              stuff_err,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid
);

  localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STUFF = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              last_bit_q, last_bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              stuff_drop_q, stuff_drop_d;
  logic              stuff_err_q, stuff_err_d;
  logic [BYTE_W-1:0] byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d;

  logic [RUN_W-1:0]  run_new;
  logic [BYTE_W-1:0] shift_new;

  // Next-state and registered-output logic for the de-stuffer FSM.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    last_bit_d   = last_bit_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    stuff_drop_d = 1'b0;
    stuff_err_d  = stuff_err_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    run_new      = '0;
    shift_new    = {shift_q[BYTE_W-2:0], rx_bit};

    if (!destuff_en) begin
      // Outside the stuffed region: discard frame history, pass bits through.
      state_d     = ST_IDLE;
      run_d       = '0;
      cnt_d       = '0;
      shift_d     = '0;
      stuff_err_d = 1'b0;
      if (sample_en) begin
        dout_d       = rx_bit;
        dout_valid_d = 1'b1;
      end
    end else if (sample_en) begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          dout_d       = rx_bit;
          dout_valid_d = 1'b1;
          // A bit arriving in IDLE starts a fresh run with no history.
          if ((state_q == ST_RUN) && (rx_bit == last_bit_q) && (run_q != '0)) begin
            run_new = run_q + RUN_W'(1);
          end else begin
            run_new    = RUN_W'(1);
            last_bit_d = rx_bit;
          end
          run_d   = run_new;
          state_d = (run_new == RUN_W'(STUFF_LEN)) ? ST_STUFF : ST_RUN;
          if (cnt_q == CNT_W'(BYTE_W - 1)) begin
            byte_out_d   = shift_new;
            byte_valid_d = 1'b1;
            cnt_d        = '0;
            shift_d      = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_new;
          end
        end
        ST_STUFF: begin
          // The stuff bit itself starts the next run.
          if (rx_bit != last_bit_q) begin
            stuff_drop_d = 1'b1;
            last_bit_d   = rx_bit;
            run_d        = RUN_W'(1);
            state_d      = ST_RUN;
          end else begin
            stuff_err_d = 1'b1;
            state_d     = ST_ERROR;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      run_q        <= '0;
      last_bit_q   <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      stuff_drop_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      last_bit_q   <= last_bit_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      stuff_drop_q <= stuff_drop_d;
      stuff_err_q  <= stuff_err_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign stuff_drop = stuff_drop_q;
  assign stuff_err  = stuff_err_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;

endmodule

// File: doc/can_bit_destuff.md
Name: can_bit_destuff

Overview:
- Receive-path bit de-stuffer for the CAN controller.
- Sits directly upstream of the seq_8 pattern detector and frame logic: takes sampled bus bits, removes CAN stuff bits, and flags stuff errors.
- Forwards the de-stuffed serial stream (dout/dout_valid) and also assembles it into bytes for the frame logic.

Parameters:
- STUFF_LEN, 5: number of equal consecutive bits after which one complementary stuff bit follows.
- BYTE_W, 8: width of the byte assembler.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-high: asserted (1) resets the block at the next rising clk; 0 is normal operation.
- sample_en  input  1  one-cycle strobe; rx_bit is valid and consumed this cycle.
- rx_bit  input  1  sampled bus bit (0 = dominant).
- destuff_en  input  1  high over the stuffed region (SOF through CRC); low elsewhere.
- dout  output  1  de-stuffed bit.
- dout_valid  output  1  one-cycle pulse; dout is valid.
- stuff_drop  output  1  one-cycle pulse; a correct stuff bit was removed.
- stuff_err  output  1  sticky stuff-error flag.
- byte_out  output  BYTE_W  last assembled byte, MSB first.
- byte_valid  output  1  one-cycle pulse; byte_out updated.

Behaviour:
- Reset (rst_n=1 at a clk edge) clears every output to 0, run counter to 0, bit counter to 0, last_bit to 0, state to IDLE.
- All outputs are registered. A bit presented with sample_en in cycle N produces dout/dout_valid/stuff_drop/stuff_err/byte_valid in cycle N+1.
- Cycles with sample_en=0 change nothing; all pulse outputs are 0.
- The block has four states: IDLE, RUN, STUFF and ERROR.
- IDLE (destuff_en=0):
  - Every sampled bit is passed through: dout=rx_bit, dout_valid=1.
  - No stuff checking; run=0; bit counter held at 0.
  - If destuff_en=1 on a sample, go to RUN and process that same bit as a RUN bit with no history.
- RUN:
  - A sampled bit is forwarded (dout_valid=1), shifted into the byte assembler, and the bit counter increments.
  - If rx_bit equals last_bit and run>0, then run=run+1; otherwise run=1 and last_bit=rx_bit.
  - When run reaches STUFF_LEN, go to STUFF.
- STUFF (the next sampled bit is a stuff bit and is not forwarded):
  - rx_bit != last_bit: stuff_drop=1, last_bit=rx_bit, run=1, go to RUN.
  - rx_bit == last_bit: stuff_err=1, go to ERROR.
- ERROR:
  - No dout_valid and no byte_valid.
  - stuff_err stays 1 until destuff_en samples 0 at any clk, which returns the block to IDLE and clears stuff_err.
- destuff_en falling in any state:
  - Next state is IDLE; run, bit counter and partial byte are discarded.
  - A sample in that same cycle is handled as an IDLE pass-through bit.
- Byte assembly (RUN only):
  - Shift register shifts left with dout entering at the LSB.
  - On the BYTE_W-th forwarded bit, byte_out is loaded with the full byte, byte_valid pulses together with that bit's dout_valid, and the bit counter wraps to 0.
- Stuff bits never advance the bit counter.
- Run counter width is clog2(STUFF_LEN+1); it never exceeds STUFF_LEN.
- Reset has priority over every other input, including a mid-frame sample.

Test Plan:
- Basic de-stuffing: destuff_en=1, send 0,0,0,0,0,1(stuff),0,1,1 -> dout_valid count 8, forwarded 0,0,0,0,0,0,1,1; stuff_drop pulses once, one cycle after the 6th sample; byte_out=8'h03 with byte_valid on the 8th forwarded bit.
- Stuff error: send 1×5 then 1 -> stuff_err=1 one cycle after the 6th sample; no further dout_valid; stuff_err clears the cycle after destuff_en=0.
- Chained stuffing: send 1,1,1,1,1,0(stuff),0,0,0,0,1(stuff) -> stuff_drop pulses twice. The stuff 0 counts toward the next run, so the second stuff bit follows the 4th forwarded 0. Forwarded stream is 1,1,1,1,1,0,0,0,0.
- Pass-through: destuff_en=0, send 0×7 -> seven dout_valid pulses, dout=0, no stuff_drop, no stuff_err, no byte_valid.
- Reset mid-run: after 4 equal bits, assert rst_n=1 for one clk, then resume with destuff_en=1 and 2 more equal bits -> no STUFF state entered (run=2), all outputs 0 during the reset cycle.
- destuff_en drop: drop destuff_en after 5 equal bits, then send 1 more equal bit -> that bit is forwarded (IDLE pass-through) with no stuff_err.
